// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// Booth digit encoding and the 3-bit window decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_e;

  // Window is {y[2i+1], y[2i], y[2i-1]}; digit = -2*b2 + b1 + b0.
  function automatic digit_e booth_enc(input logic [2:0] win);
    digit_e d;
    d = ZERO;
    case (win)
      3'b000, 3'b111: d = ZERO;
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Combinational Booth partial-product generator: returns digit*X as an
// EW+1-bit two's complement value. X is an EW-bit extended operand whose
// magnitude fits in EW-1 bits, so +-2X always fits in EW+1 bits.
module booth_r4_pp
  import booth_pkg::*;
#(
  parameter int EW = 66
) (
  input  logic [EW-1:0] x,
  input  digit_e        digit,
  output logic [EW:0]   pp
);

  logic [EW:0] x1;
  logic [EW:0] x2;

  assign x1 = {x[EW-1], x};
  assign x2 = {x, 1'b0};

  // Select the multiple of X named by the Booth digit.
  always_comb begin
    pp = '0;
    case (digit)
      ZERO:    pp = '0;
      POS1:    pp = x1;
      POS2:    pp = x2;
      NEG1:    pp = -x1;
      NEG2:    pp = -x2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one Booth digit retired per clock.
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high; ready never depends on valid, and a producer holding valid
// must keep its data stable until the transfer edge.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int EW    = WIDTH + 2;
  localparam int NITER = EW / 2;
  localparam int AW    = 2 * EW;
  localparam int CW    = $clog2(NITER + 1);

  state_e          state_q, state_d;
  logic [EW-1:0]   x_q, x_d;
  logic [EW-1:0]   y_q, y_d;
  logic            yprev_q, yprev_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  digit_e          digit;
  logic [EW:0]     pp;
  logic [AW-1:0]   pp_ext;
  logic            unused_acc_hi;

  // y_q shifts right two bits per digit, so the current window is always
  // at the bottom; yprev_q carries y[2i-1] (zero for the first digit).
  assign digit  = booth_enc({y_q[1], y_q[0], yprev_q});
  assign pp_ext = {{(AW-EW-1){pp[EW]}}, pp};

  booth_r4_pp #(.EW(EW)) u_pp (
    .x     (x_q),
    .digit (digit),
    .pp    (pp)
  );

  // Next-state, operand capture and accumulate logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    yprev_d = yprev_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          x_d     = signed_mode ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
          y_d     = signed_mode ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};
          yprev_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        acc_d   = acc_q + (pp_ext << {cnt_q, 1'b0});
        y_d     = {2'b00, y_q[EW-1:2]};
        yprev_d = y_q[1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NITER - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      yprev_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      yprev_q <= yprev_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // The top accumulator bits only exist to keep the sum exact at 2*EW bits.
  assign unused_acc_hi = ^acc_q[AW-1:2*WIDTH];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign z         = out_valid ? acc_q[2*WIDTH-1:0] : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed bench for booth_r4_seq_mult at WIDTH=64 and WIDTH=8.
module tb_booth_r4_seq_mult;

  localparam int NA = 33;  // Booth digits at WIDTH=64
  localparam int NB = 5;   // Booth digits at WIDTH=8

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=64 instance
  logic         a_in_valid, a_in_ready, a_sm, a_out_valid, a_out_ready, a_busy;
  logic [63:0]  a_x, a_y;
  logic [127:0] a_z;
  logic [1:0]   a_dbg;

  // WIDTH=8 instance
  logic         b_in_valid, b_in_ready, b_sm, b_out_valid, b_out_ready, b_busy;
  logic [7:0]   b_x, b_y;
  logic [15:0]  b_z;
  logic [1:0]   b_dbg;

  booth_r4_seq_mult #(.WIDTH(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .signed_mode(a_sm), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .z(a_z), .busy(a_busy), .dbg_state(a_dbg)
  );

  booth_r4_seq_mult #(.WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .signed_mode(b_sm), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .z(b_z), .busy(b_busy), .dbg_state(b_dbg)
  );

  // scoreboard counters
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: one WIDTH=64 operation with a consumer stall after out_valid
  task automatic run_a(input string tag, input logic [63:0] xv, input logic [63:0] yv,
                       input logic m, input int stall, input logic [127:0] exp);
    int k;
    @(negedge clk);
    a_x = xv; a_y = yv; a_sm = m; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_x = {$urandom, $urandom}; a_y = {$urandom, $urandom}; a_sm = ~m;
    check({tag, ":busy"}, 128'(a_busy), 128'd1);
    k = 0;
    while (!a_out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, ":lat"}, 128'(k), 128'(NA));
    check({tag, ":z"}, a_z, exp);
    check({tag, ":in_ready"}, 128'(a_in_ready), 128'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, ":stall_z"}, a_z, exp);
      check({tag, ":stall_ov"}, 128'(a_out_valid), 128'd1);
      check({tag, ":stall_ir"}, 128'(a_in_ready), 128'd0);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check({tag, ":ov_after"}, 128'(a_out_valid), 128'd0);
    check({tag, ":ir_after"}, 128'(a_in_ready), 128'd1);
  endtask

  // driver: one WIDTH=8 operation
  task automatic run_b(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                       input logic m, input int stall, input logic [15:0] exp);
    int k;
    @(negedge clk);
    b_x = xv; b_y = yv; b_sm = m; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_x = 8'($urandom); b_y = 8'($urandom); b_sm = ~m;
    k = 0;
    while (!b_out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, ":lat"}, 128'(k), 128'(NB));
    check({tag, ":z"}, 128'(b_z), 128'(exp));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, ":stall_z"}, 128'(b_z), 128'(exp));
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check({tag, ":ir_after"}, 128'(b_in_ready), 128'd1);
  endtask

  // reference model for the WIDTH=8 random section
  function automatic logic [15:0] model8(input logic [7:0] xv, input logic [7:0] yv, input logic m);
    logic [15:0] xe, ye;
    xe = m ? {{8{xv[7]}}, xv} : {8'h00, xv};
    ye = m ? {{8{yv[7]}}, yv} : {8'h00, yv};
    return xe * ye;
  endfunction

  initial begin
    logic [7:0] rx, ry;
    logic       rm;
    a_in_valid = 0; a_x = '0; a_y = '0; a_sm = 0; a_out_ready = 0;
    b_in_valid = 0; b_x = '0; b_y = '0; b_sm = 0; b_out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(a_in_ready), 128'd1);
    check("rst_out_valid", 128'(a_out_valid), 128'd0);
    check("rst_busy", 128'(a_busy), 128'd0);
    check("rst_z", a_z, 128'd0);
    check("rst_state", 128'(a_dbg), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_a("s100xm300", 64'd100, -64'sd300, 1'b1, 0,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_8AD0);
    run_a("umax_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run_a("sm1_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 128'h1);
    run_a("smin_sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 0,
          128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run_a("stall7x6", 64'd7, 64'd6, 1'b0, 5, 128'd42);

    // reset in the middle of CALC
    @(negedge clk);
    a_x = 64'd9; a_y = 64'd9; a_sm = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", 128'(a_busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ov", 128'(a_out_valid), 128'd0);
    check("midrst_ir", 128'(a_in_ready), 128'd1);
    check("midrst_z", a_z, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a("post_rst_3x5", 64'd3, 64'd5, 1'b0, 0, 128'd15);

    // WIDTH=8 corner vectors
    run_b("b_smin_sq", 8'h80, 8'h80, 1'b1, 0, 16'h4000);
    run_b("b_umax_sq", 8'hFF, 8'hFF, 1'b0, 2, 16'hFE01);
    run_b("b_m1x127", 8'hFF, 8'h7F, 1'b1, 1, 16'hFF81);
    run_b("b_u128x2", 8'h80, 8'h02, 1'b0, 0, 16'h0100);
    run_b("b_min_x1", 8'h80, 8'h01, 1'b1, 3, 16'hFF80);

    // WIDTH=8 random operands and stalls against the model
    for (int i = 0; i < 60; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      run_b("b_rand", rx, ry, rm, $urandom_range(0, 3), model8(rx, ry, rm));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
